dec_lut_search_param: RTL and testbench
=======================================

Name: dec_lut_search_param

Overview:
- Parametrised, programmable successor to the fixed 8-bit clocked LUT decoder.
- Holds a DEPTH-entry table of W_BITS-wide codewords, loaded through a write port.
- On a start handshake, searches the table for an input codeword W, comparing LANES entries per cycle.
- Returns the matching index N with found/done flags; supports exact-match and floor (largest value ≤ W) modes.

Parameters:
W_BITS, 20, codeword width
IDX_BITS, 9, index/result width; must satisfy 2^IDX_BITS > DEPTH-1
DEPTH, 256, table entries; must be a multiple of LANES
LANES, 4, entries compared per search cycle; power of two, 1..DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request a search; accepted only when ready=1
ready  output  1  high in IDLE: can accept start or writes
mode  input  1  0 = exact match, 1 = floor match; sampled with start
W  input  W_BITS  search key; sampled with start
wr_en  input  1  table write strobe; honoured only when ready=1
wr_addr  input  IDX_BITS  write index; values ≥ DEPTH are ignored
wr_data  input  W_BITS  write data
busy  output  1  high while searching
done  output  1  one-cycle pulse when the result is valid
found  output  1  result flag, held until the next accepted start
N  output  IDX_BITS  result index, held until the next accepted start

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, ready=1, busy=0, done=0, found=0, N=0.
  - All table entries are cleared to 0.
  - Reset mid-search aborts the search with no done pulse.
- FSM states: IDLE, SEARCH, FINISH.
  - IDLE --(start)--> SEARCH. On the accepting edge: latch W and mode, ptr=0, clear found and N, best_valid=0.
  - SEARCH: each cycle compares entries ptr..ptr+LANES-1 (unsigned) against the latched W, then ptr += LANES.
  - SEARCH -> FINISH:
    - exact mode: on the first cycle with any lane hit, or when ptr+LANES == DEPTH.
    - floor mode: only when ptr+LANES == DEPTH (full scan, no early exit).
  - FINISH: drive done=1 for exactly one cycle with found and N valid, then return to IDLE (ready=1 the same edge done falls).
- Result rules:
  - exact: N = lowest index whose entry == W; found=1.
  - floor: N = highest index whose entry ≤ W, across all lanes and all cycles (highest lane wins within a cycle); found=1.
  - No qualifying entry: found=0, N = all ones (2^IDX_BITS-1).
- Latency, counted from the accepting start edge to the edge where done rises:
  - exact hit at index k: floor(k/LANES)+2 cycles.
  - exact miss or any floor search: DEPTH/LANES+1 cycles.
- Handshake and concurrency:
  - start while ready=0 is ignored; no queuing.
  - wr_en while ready=0 is dropped silently; the table never changes during a search.
  - start and wr_en in the same IDLE cycle: the write commits on that edge and the search sees the new value.
  - start may be held high: a new search is accepted on the cycle ready returns high.
- Arithmetic:
  - Comparisons are unsigned and full W_BITS.
  - ptr is IDX_BITS wide and never wraps, since the search terminates at DEPTH.
  - DEPTH=LANES gives a single-cycle scan.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then load entry[i]=i*3 for i=0..255; start, mode=0, W=765 -> found=1, N=255, done at cycle 65 (LANES=4), ready high one cycle after done.
- Same table; start, mode=0, W=9 -> N=3, found=1, done at cycle 2. Then W=10 (absent) -> found=0, N=511, done at cycle 65.
- Same table; mode=1, W=10 -> N=3; mode=1, W=0xFFFFF -> N=255; rewrite entry[0]=5, mode=1, W=2 -> found=0, N=511.
- Duplicates: entry[40]=entry[41]=entry[200]=777 (rest distinct) -> exact gives N=40; floor with W=777 gives N=200.
- Assert rst at cycle 10 of a 65-cycle search -> no done pulse, outputs zero, table all zero. After release, start W=0 mode=0 -> N=0, found=1, done at cycle 2.
- During a search, pulse wr_en (addr 7, data 1234) and start -> both ignored, result unchanged. After return to IDLE, search W=1234 -> found=0.

Source files
------------

// File: rtl/dec_lut_search_param.sv
`default_nettype none
// ============================================================================
// Module   : dec_lut_search_param
// Purpose  : Programmable DEPTH-entry codeword table searched LANES entries per
//            cycle, returning exact-match or floor-match index.
// Revision : 1.0
// ============================================================================
module dec_lut_search_param #(
  parameter int W_BITS   = 20,
  parameter int IDX_BITS = 9,
  parameter int DEPTH    = 256,
  parameter int LANES    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic                mode,
  input  logic [W_BITS-1:0]   W,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_addr,
  input  logic [W_BITS-1:0]   wr_data,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [IDX_BITS-1:0] N
);

  localparam int                c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_BITS:0] c_DEPTH    = (IDX_BITS+1)'(DEPTH);
  localparam logic [IDX_BITS-1:0] c_LAST_PTR = IDX_BITS'(DEPTH - LANES);
  localparam logic [IDX_BITS-1:0] c_LANES    = IDX_BITS'(LANES);
  localparam logic [IDX_BITS-1:0] c_NONE     = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state, w_next;
  logic [W_BITS-1:0]     r_table [DEPTH];
  logic [W_BITS-1:0]     r_key;
  logic                  r_mode;
  logic [IDX_BITS-1:0]   r_ptr;
  logic [IDX_BITS-1:0]   r_best;
  logic                  r_best_valid;
  logic                  r_found;
  logic [IDX_BITS-1:0]   r_n;
  logic                  r_done;

  logic [W_BITS-1:0]     w_lane_data [LANES];
  logic                  w_any_hit, w_any_le, w_last, w_term, w_wr_ok;
  logic [IDX_BITS-1:0]   w_hit_idx, w_le_idx;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_data[l] = r_table[r_ptr[c_AW-1:0] + c_AW'(l)];
  end

  // Exact keeps the lowest hitting lane, floor keeps the highest qualifying lane.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_idx = c_NONE;
    w_any_le  = 1'b0;
    w_le_idx  = c_NONE;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_lane_data[l] == r_key) begin
        w_any_hit = 1'b1;
        w_hit_idx = r_ptr + IDX_BITS'(l);
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_data[l] <= r_key) begin
        w_any_le = 1'b1;
        w_le_idx = r_ptr + IDX_BITS'(l);
      end
    end
  end

  assign w_last  = (r_ptr == c_LAST_PTR);
  assign w_term  = w_last || (!r_mode && w_any_hit);
  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FINISH spans two cycles: results settle, then done pulses while ready is low.
  always_comb begin
    w_next = r_state;
    ready  = (r_state == S_IDLE);
    busy   = (r_state == S_SEARCH);
    done   = r_done;
    found  = r_found;
    N      = r_n;
    case (r_state)
      S_IDLE:   if (start)  w_next = S_SEARCH;
      S_SEARCH: if (w_term) w_next = S_FINISH;
      S_FINISH: if (r_done) w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
      r_key        <= '0;
      r_mode       <= 1'b0;
      r_ptr        <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_found      <= 1'b0;
      r_n          <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH) && !r_done;
      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) r_table[wr_addr[c_AW-1:0]] <= wr_data;
          if (start) begin
            r_key        <= W;
            r_mode       <= mode;
            r_ptr        <= '0;
            r_found      <= 1'b0;
            r_n          <= '0;
            r_best_valid <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (!w_term) r_ptr <= r_ptr + c_LANES;
          if (!r_mode) begin
            if (w_any_hit) begin
              r_found <= 1'b1;
              r_n     <= w_hit_idx;
            end else if (w_last) begin
              r_found <= 1'b0;
              r_n     <= c_NONE;
            end
          end else begin
            if (w_any_le) begin
              r_best       <= w_le_idx;
              r_best_valid <= 1'b1;
            end
            if (w_last) begin
              if (w_any_le) begin
                r_found <= 1'b1;
                r_n     <= w_le_idx;
              end else if (r_best_valid) begin
                r_found <= 1'b1;
                r_n     <= r_best;
              end else begin
                r_found <= 1'b0;
                r_n     <= c_NONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_lut_search_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_lut_search_param
// Purpose  : Scoreboard bench for dec_lut_search_param with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_dec_lut_search_param;
  localparam int W_BITS   = 20;
  localparam int IDX_BITS = 9;
  localparam int DEPTH    = 256;
  localparam int LANES    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                mode = 1'b0;
  logic                wr_en = 1'b0;
  logic [W_BITS-1:0]   W = '0;
  logic [W_BITS-1:0]   wr_data = '0;
  logic [IDX_BITS-1:0] wr_addr = '0;
  logic [IDX_BITS-1:0] N;
  logic                ready, busy, done, found;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic                found;
    logic [IDX_BITS-1:0] n;
    int                  acc;
    int                  lat;
    string               name;
  } exp_t;

  exp_t q[$];
  exp_t e;

  dec_lut_search_param #(
    .W_BITS(W_BITS), .IDX_BITS(IDX_BITS), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .mode(mode), .W(W),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .found(found), .N(N)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected response", name);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (prev_done) chk("ready_after_done", int'(ready), 1);
    prev_done = done;
    if (done) begin
      chk("ready_low_with_done", int'(ready), 0);
      if (q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_found"}, int'(found), int'(e.found));
        chk({e.name, "_N"}, int'(N), int'(e.n));
        chk({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic push(input logic ef, input int en, input int lat, input string name);
    exp_t x;
    x.found = ef;
    x.n     = IDX_BITS'(en);
    x.acc   = cyc + 1;
    x.lat   = lat;
    x.name  = name;
    q.push_back(x);
  endtask

  task automatic wait_empty(input string name);
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      fail({name, "_done_timeout"});
      q.delete();
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) fail({name, "_ready_timeout"});
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = IDX_BITS'(a);
    wr_data = W_BITS'(d);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic search(input logic m, input int w, input logic ef, input int en,
                        input int lat, input string name);
    wait_ready(name);
    start = 1'b1;
    mode  = m;
    W     = W_BITS'(w);
    push(ef, en, lat, name);
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_N", int'(N), 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(i, i * 3);
    search(1'b0, 765, 1'b1, 255, 65, "ex_765");
    search(1'b0, 9, 1'b1, 3, 2, "ex_9");
    search(1'b0, 10, 1'b0, 511, 65, "ex_10_miss");
    search(1'b1, 10, 1'b1, 3, 65, "fl_10");
    search(1'b1, 20'hFFFFF, 1'b1, 255, 65, "fl_max");
    search(1'b0, 18, 1'b1, 6, 3, "ex_18");
    wr(0, 5);
    search(1'b1, 2, 1'b0, 511, 65, "fl_2_none");
    search(1'b0, 5, 1'b1, 0, 2, "ex_5");

    wr(40, 777);
    wr(41, 777);
    wr(200, 777);
    for (int i = 201; i < DEPTH; i++) wr(i, 1000 + i);
    search(1'b0, 777, 1'b1, 40, 12, "dup_ex");
    search(1'b1, 777, 1'b1, 200, 65, "dup_fl");
    search(1'b1, 776, 1'b1, 199, 65, "fl_776");
    wr(300, 2);
    search(1'b1, 2, 1'b0, 511, 65, "oob_write");

    // Abort a long exact-miss search with reset partway through.
    wait_ready("abort");
    start = 1'b1;
    mode  = 1'b0;
    W     = W_BITS'(10);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_busy", int'(busy), 1);
    chk("mid_ready", int'(ready), 0);
    rst = 1'b1;
    #1;
    chk("abort_done", int'(done), 0);
    chk("abort_found", int'(found), 0);
    chk("abort_N", int'(N), 0);
    chk("abort_ready", int'(ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    search(1'b0, 0, 1'b1, 0, 2, "post_rst_ex0");
    search(1'b1, 0, 1'b1, 255, 65, "post_rst_fl0");
    search(1'b0, 777, 1'b0, 511, 65, "post_rst_cleared");

    // Write and start issued mid-search must both be dropped.
    wait_ready("busy_fl");
    start = 1'b1;
    mode  = 1'b1;
    W     = '0;
    push(1'b1, 255, 65, "busy_fl");
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = IDX_BITS'(7);
    wr_data = W_BITS'(1234);
    start   = 1'b1;
    mode    = 1'b0;
    W       = W_BITS'(1234);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
    wait_empty("busy_fl");
    search(1'b0, 1234, 1'b0, 511, 65, "dropped_write");

    // Write and start in the same idle cycle: search sees the new entry.
    wait_ready("wr_start");
    wr_en   = 1'b1;
    wr_addr = IDX_BITS'(100);
    wr_data = W_BITS'(4242);
    start   = 1'b1;
    mode    = 1'b0;
    W       = W_BITS'(4242);
    push(1'b1, 100, 27, "wr_start");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
    wait_empty("wr_start");

    // Start held high: second search is accepted as soon as ready returns.
    wait_ready("held");
    start = 1'b1;
    mode  = 1'b0;
    W     = '0;
    push(1'b1, 0, 2, "held_a");
    begin
      exp_t x;
      x.found = 1'b1;
      x.n     = '0;
      x.acc   = cyc + 5;
      x.lat   = 2;
      x.name  = "held_b";
      q.push_back(x);
    end
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    wait_empty("held");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
